// File: rtl/barrel_shifter_mux.sv
// barrel_shifter_mux
//   Registered barrel shifter/rotator built from SHIFTWIDTH stages of 2:1 muxes.
//   Stage k moves the word by 2^k positions when shift_val[k] is set.
//   Result appears on data_out one clock after the inputs are sampled.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active HIGH (1 = clear data_out)
//   data_in    operand word
//   shift_val  shift/rotate amount, 0..BUSWIDTH-1
//   rotation   1 = rotate (wrap), 0 = logical shift (zero fill)
//   direction  0 = left (toward MSB), 1 = right (toward LSB)
//   data_out   registered result
module barrel_shifter_mux #(
    parameter int unsigned BUSWIDTH   = 16,
    parameter int unsigned SHIFTWIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BUSWIDTH-1:0]   data_in,
    input  logic [SHIFTWIDTH-1:0] shift_val,
    input  logic                  rotation,
    input  logic                  direction,
    output logic [BUSWIDTH-1:0]   data_out
);

    // stage[0] is the input word, stage[SHIFTWIDTH] the fully shifted word
    logic [SHIFTWIDTH:0][BUSWIDTH-1:0] stage;
    logic [BUSWIDTH-1:0]               data_d;
    logic [BUSWIDTH-1:0]               data_q;

    always_comb begin
        int src;
        src   = 0;
        stage = '0;
        stage[0] = data_in;
        for (int k = 0; k < int'(SHIFTWIDTH); k++) begin
            stage[k+1] = stage[k];
            if (shift_val[k]) begin
                for (int i = 0; i < int'(BUSWIDTH); i++) begin
                    // Source bit for output bit i; out-of-range means wrap or zero fill
                    src = direction ? (i + (1 << k)) : (i - (1 << k));
                    if (src >= 0 && src < int'(BUSWIDTH)) begin
                        stage[k+1][i] = stage[k][src];
                    end else if (rotation) begin
                        if (src < 0) begin
                            stage[k+1][i] = stage[k][src + int'(BUSWIDTH)];
                        end else begin
                            stage[k+1][i] = stage[k][src - int'(BUSWIDTH)];
                        end
                    end else begin
                        stage[k+1][i] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        data_d = stage[SHIFTWIDTH];
    end

    // rst_n is active high despite its name
    always_ff @(posedge clk) begin
        if (rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: tb/tb_barrel_shifter_mux.sv
// Self-checking bench for barrel_shifter_mux: directed vectors from the test plan,
// a mid-stream reset, and a short run of random vectors against a reference model.
module tb_barrel_shifter_mux;

    localparam int unsigned BW = 16;
    localparam int unsigned SW = 4;

    logic          clk;
    logic          rst_n;
    logic [BW-1:0] data_in;
    logic [SW-1:0] shift_val;
    logic          rotation;
    logic          direction;
    logic [BW-1:0] data_out;

    logic [BW-1:0] exp_q[$];
    int            n_total;
    int            n_pass;

    barrel_shifter_mux #(
        .BUSWIDTH  (BW),
        .SHIFTWIDTH(SW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .shift_val(shift_val),
        .rotation (rotation),
        .direction(direction),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model using a doubled word for rotation
    function automatic logic [BW-1:0] model(input logic [BW-1:0] d, input int n,
                                            input logic rot, input logic dir);
        logic [2*BW-1:0] w;
        logic [BW-1:0]   r;
        if (rot) begin
            w = {d, d};
            if (!dir) begin
                w = w << n;
                r = w[2*BW-1:BW];
            end else begin
                w = w >> n;
                r = w[BW-1:0];
            end
        end else begin
            r = dir ? (d >> n) : (d << n);
        end
        return r;
    endfunction

    // Drive one cycle of stimulus on the falling edge, push the expectation,
    // then compare just after the next rising edge.
    task automatic step(input string tag, input logic rst, input logic [BW-1:0] d,
                        input logic [SW-1:0] s, input logic rot, input logic dir,
                        input logic [BW-1:0] exp);
        logic [BW-1:0] e;
        @(negedge clk);
        rst_n     = rst;
        data_in   = d;
        shift_val = s;
        rotation  = rot;
        direction = dir;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: scoreboard empty, observed %h", tag, data_out);
        end else begin
            e = exp_q.pop_front();
            assert (data_out === e) begin
                n_pass++;
            end else begin
                $error("FAIL %s: observed %h expected %h", tag, data_out, e);
            end
        end
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst_n     = 1'b1;
        data_in   = 16'h1234;
        shift_val = 4'd3;
        rotation  = 1'b1;
        direction = 1'b0;

        // Reset with arbitrary inputs
        step("reset0", 1'b1, 16'hFFFF, 4'd5, 1'b1, 1'b0, 16'h0000);
        step("reset1", 1'b1, 16'h5A5A, 4'd9, 1'b0, 1'b1, 16'h0000);

        // Main vectors, back-to-back
        step("rotl1",  1'b0, 16'h88AB, 4'd1,  1'b1, 1'b0, 16'h1157);
        step("rotr8",  1'b0, 16'h9126, 4'd8,  1'b1, 1'b1, 16'h2691);
        step("shl2",   1'b0, 16'h3124, 4'd2,  1'b0, 1'b0, 16'hC490);
        step("shr10",  1'b0, 16'h29CE, 4'd10, 1'b0, 1'b1, 16'h000A);

        // Zero shift in all four modes
        step("zero_shl", 1'b0, 16'hA5C3, 4'd0, 1'b0, 1'b0, 16'hA5C3);
        step("zero_shr", 1'b0, 16'hA5C3, 4'd0, 1'b0, 1'b1, 16'hA5C3);
        step("zero_rol", 1'b0, 16'hA5C3, 4'd0, 1'b1, 1'b0, 16'hA5C3);
        step("zero_ror", 1'b0, 16'hA5C3, 4'd0, 1'b1, 1'b1, 16'hA5C3);

        // Maximum shift
        step("max_rol", 1'b0, 16'h8001, 4'd15, 1'b1, 1'b0, 16'hC000);
        step("max_shl", 1'b0, 16'h8001, 4'd15, 1'b0, 1'b0, 16'h8000);
        step("max_shr", 1'b0, 16'h8001, 4'd15, 1'b0, 1'b1, 16'h0001);
        step("max_ror", 1'b0, 16'h8001, 4'd15, 1'b1, 1'b1, 16'h0003);

        // Back-to-back with a mid-stream reset
        step("b2b_rotl1", 1'b0, 16'h88AB, 4'd1,  1'b1, 1'b0, 16'h1157);
        step("b2b_rotr8", 1'b0, 16'h9126, 4'd8,  1'b1, 1'b1, 16'h2691);
        step("b2b_reset", 1'b1, 16'h3124, 4'd2,  1'b0, 1'b0, 16'h0000);
        step("b2b_shl2",  1'b0, 16'h3124, 4'd2,  1'b0, 1'b0, 16'hC490);
        step("b2b_shr10", 1'b0, 16'h29CE, 4'd10, 1'b0, 1'b1, 16'h000A);

        // Random vectors against the model
        for (int i = 0; i < 64; i++) begin
            logic [BW-1:0] d;
            logic [SW-1:0] s;
            logic          r;
            logic          dr;
            d  = BW'($urandom);
            s  = SW'($urandom_range(0, BW - 1));
            r  = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            step("rand", 1'b0, d, s, r, dr, model(d, int'(s), r, dr));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
